delay_ctrl_multi: RTL and testbench



---
 rtl/delay_ctrl_multi_if.sv | 21 ++
 rtl/delay_ctrl_multi.sv | 132 +++++++++++++
 tb/tb_delay_ctrl_multi.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/delay_ctrl_multi_if.sv
// Avalon-MM-style slave bus carrying register access to the delay channels.
interface delay_ctrl_multi_if #(
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                  chipselect;
  logic                  write;
  logic                  read;
  logic [ADDR_WIDTH-1:0] address;
  logic [7:0]            writedata;
  logic [7:0]            readdata;

  modport master (
    output chipselect, write, read, address, writedata,
    input  readdata
  );

  modport slave (
    input  chipselect, write, read, address, writedata,
    output readdata
  );
endinterface

// File: rtl/delay_ctrl_multi.sv
// Multi-channel saturating delay controller. Each channel is stepped by
// faster/slower strobes with press-and-hold auto-repeat, or written and read
// over the slave bus.
module delay_ctrl_multi #(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned MIN_DELAY     = 1,
  parameter int unsigned MAX_DELAY     = 15,
  parameter int unsigned RESET_DELAY   = 8,
  parameter int unsigned REPEAT_CYCLES = 4,
  parameter int unsigned ADDR_WIDTH    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       faster,
  input  logic [CHANNELS-1:0]       slower,
  output logic [CHANNELS*WIDTH-1:0] delay,
  delay_ctrl_multi_if.slave         bus
);

  localparam int unsigned CntW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [CntW-1:0]  CntReload = CntW'(REPEAT_CYCLES - 1);
  localparam logic [WIDTH-1:0] MinVal    = WIDTH'(MIN_DELAY);
  localparam logic [WIDTH-1:0] MaxVal    = WIDTH'(MAX_DELAY);
  localparam logic [WIDTH-1:0] RstVal    = WIDTH'(RESET_DELAY);

  typedef enum logic [1:0] {StIdle, StHeldF, StHeldS} state_e;

  state_e           state_q [CHANNELS];
  logic [CntW-1:0]  cnt_q   [CHANNELS];
  logic [WIDTH-1:0] delay_q [CHANNELS];
  logic [7:0]       readdata_q;

  logic [WIDTH-1:0] step_dn [CHANNELS];
  logic [WIDTH-1:0] step_up [CHANNELS];
  logic [CHANNELS-1:0] wr_hit;
  logic [WIDTH-1:0] wr_val;
  logic [7:0]       rd_val;

  // Saturating neighbours of each channel value.
  always_comb begin
    for (int i = 0; i < int'(CHANNELS); i++) begin
      step_dn[i] = (delay_q[i] == MinVal) ? delay_q[i] : delay_q[i] - WIDTH'(1);
      step_up[i] = (delay_q[i] == MaxVal) ? delay_q[i] : delay_q[i] + WIDTH'(1);
    end
  end

  // Address decode and write clamping; out-of-range addresses hit nothing.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      wr_hit[i] = bus.chipselect & bus.write & (bus.address == ADDR_WIDTH'(i));
      if (bus.address == ADDR_WIDTH'(i)) rd_val = 8'(delay_q[i]);
    end
    if (bus.writedata < 8'(MIN_DELAY))      wr_val = MinVal;
    else if (bus.writedata > 8'(MAX_DELAY)) wr_val = MaxVal;
    else                                    wr_val = bus.writedata[WIDTH-1:0];
  end

  // Per-channel press FSM, repeat counter, delay value and read register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        state_q[i] <= StIdle;
        cnt_q[i]   <= '0;
        delay_q[i] <= RstVal;
      end
      readdata_q <= '0;
    end else begin
      if (bus.chipselect && bus.read) readdata_q <= rd_val;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        if (wr_hit[i]) begin
          // Write wins the value and restarts the repeat interval, but the
          // press tracking still advances so a held button is not re-stepped.
          delay_q[i] <= wr_val;
          cnt_q[i]   <= CntReload;
          if (faster[i] && slower[i]) state_q[i] <= StIdle;
          else if (faster[i]) state_q[i] <= (state_q[i] == StHeldS) ? StIdle : StHeldF;
          else if (slower[i]) state_q[i] <= (state_q[i] == StHeldF) ? StIdle : StHeldS;
          else                state_q[i] <= StIdle;
        end else if (faster[i] && slower[i]) begin
          state_q[i] <= StIdle;
        end else begin
          case (state_q[i])
            StIdle: begin
              if (faster[i]) begin
                delay_q[i] <= step_dn[i];
                cnt_q[i]   <= CntReload;
                state_q[i] <= StHeldF;
              end else if (slower[i]) begin
                delay_q[i] <= step_up[i];
                cnt_q[i]   <= CntReload;
                state_q[i] <= StHeldS;
              end
            end
            StHeldF: begin
              if (!faster[i]) begin
                state_q[i] <= StIdle;
              end else if (cnt_q[i] == '0) begin
                delay_q[i] <= step_dn[i];
                cnt_q[i]   <= CntReload;
              end else begin
                cnt_q[i] <= cnt_q[i] - CntW'(1);
              end
            end
            StHeldS: begin
              if (!slower[i]) begin
                state_q[i] <= StIdle;
              end else if (cnt_q[i] == '0) begin
                delay_q[i] <= step_up[i];
                cnt_q[i]   <= CntReload;
              end else begin
                cnt_q[i] <= cnt_q[i] - CntW'(1);
              end
            end
            default: state_q[i] <= StIdle;
          endcase
        end
      end
    end
  end

  // Flatten channel values onto the output bus.
  always_comb begin
    for (int i = 0; i < int'(CHANNELS); i++) begin
      delay[i*WIDTH +: WIDTH] = delay_q[i];
    end
  end

  assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_delay_ctrl_multi.sv
// Self-checking bench for delay_ctrl_multi with default parameters.
module tb_delay_ctrl_multi;

  logic        clk;
  logic        reset;
  logic [3:0]  faster;
  logic [3:0]  slower;
  logic [15:0] delay;

  int errors = 0;
  int checks = 0;
  logic [7:0] sb[$];

  delay_ctrl_multi_if #(.ADDR_WIDTH(4)) bus ();

  delay_ctrl_multi dut (
    .clk    (clk),
    .reset  (reset),
    .faster (faster),
    .slower (slower),
    .delay  (delay),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] ch(input int n);
    return delay[n*4 +: 4];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ch(input string name, input int n, input logic [3:0] exp);
    checks++;
    if (ch(n) !== exp) begin
      errors++;
      $display("FAIL %s: ch%0d got %0d expected %0d", name, n, ch(n), exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [3:0] e0, input logic [3:0] e1,
                         input logic [3:0] e2, input logic [3:0] e3);
    chk_ch(name, 0, e0);
    chk_ch(name, 1, e1);
    chk_ch(name, 2, e2);
    chk_ch(name, 3, e3);
  endtask

  // Pop the scoreboard and compare against readdata registered on the last edge.
  task automatic chk_read(input string name);
    logic [7:0] exp;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, readdata got %0h", name, bus.readdata);
    end else begin
      exp = sb.pop_front();
      if (bus.readdata !== exp) begin
        errors++;
        $display("FAIL %s: readdata got %0h expected %0h", name, bus.readdata, exp);
      end
    end
  endtask

  task automatic bus_write(input logic [3:0] addr, input logic [7:0] data);
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.address    = addr;
    bus.writedata  = data;
    tick();
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
  endtask

  task automatic bus_read(input string name, input logic [3:0] addr, input logic [7:0] exp);
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.address    = addr;
    sb.push_back(exp);
    tick();
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    chk_read(name);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    faster = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_ch("reset_hold", 0, 4'd8);
    end
    chk_all("reset_vals", 4'd8, 4'd8, 4'd8, 4'd8);
    checks++;
    if (bus.readdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_readdata: got %0h expected 00", bus.readdata);
    end
    faster = 4'b0000;
    tick();
    reset = 1'b0;
    tick();
    chk_all("post_reset", 4'd8, 4'd8, 4'd8, 4'd8);
  endtask

  task automatic test_hold_repeat();
    logic [3:0] exp;
    faster = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      tick();
      exp = 4'(8 - (k / 4 + 1));
      chk_ch("hold_step", 0, exp);
    end
    chk_all("hold_others", 4'd5, 4'd8, 4'd8, 4'd8);
    faster = 4'b0000;
    tick();
    tick();
    chk_ch("hold_release", 0, 4'd5);
  endtask

  task automatic test_saturation();
    int zero_seen = 0;
    slower = 4'b0010;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (ch(1) == 4'd0) zero_seen++;
    end
    checks++;
    if (zero_seen != 0) begin
      errors++;
      $display("FAIL sat_no_wrap: zero seen %0d times expected 0", zero_seen);
    end
    chk_ch("sat_max", 1, 4'd15);
    slower = 4'b0000;
    tick();
    bus_read("read_ch1", 4'd1, 8'h0F);
    faster = 4'b0010;
    for (int k = 0; k < 100; k++) tick();
    chk_ch("sat_min", 1, 4'd1);
    faster = 4'b0000;
    tick();
    chk_all("sat_others", 4'd5, 4'd1, 4'd8, 4'd8);
  endtask

  task automatic test_write();
    bus_write(4'd2, 8'h00);
    chk_ch("wr_clamp_lo", 2, 4'd1);
    bus_write(4'd2, 8'h14);
    chk_ch("wr_clamp_hi", 2, 4'd15);
    bus_write(4'd2, 8'h06);
    chk_ch("wr_plain", 2, 4'd6);
    bus_write(4'd5, 8'h03);
    chk_all("wr_out_of_range", 4'd5, 4'd1, 4'd6, 4'd8);
    // Write and first press on the same cycle.
    faster = 4'b0100;
    bus_write(4'd2, 8'h0A);
    chk_ch("wr_press", 2, 4'd10);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_ch("wr_press_wait", 2, 4'd10);
    end
    tick();
    chk_ch("wr_press_step", 2, 4'd9);
    faster = 4'b0000;
    tick();
  endtask

  task automatic test_both_buttons();
    faster = 4'b1000;
    slower = 4'b1000;
    for (int k = 0; k < 8; k++) tick();
    chk_ch("both_hold", 3, 4'd8);
    slower = 4'b0000;
    tick();
    chk_ch("both_drop_slower", 3, 4'd7);
    faster = 4'b0000;
    tick();
    chk_all("both_others", 4'd5, 4'd1, 4'd9, 4'd7);
  endtask

  task automatic test_read();
    bus_read("read_oob", 4'd7, 8'h00);
    // Read and write of the same channel together return the old value.
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.write      = 1'b1;
    bus.address    = 4'd0;
    bus.writedata  = 8'h03;
    sb.push_back(8'h05);
    tick();
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    chk_read("read_old");
    chk_ch("rw_new_val", 0, 4'd3);
    bus_read("read_new", 4'd0, 8'h03);
    bus.address = 4'd2;
    tick();
    checks++;
    if (bus.readdata !== 8'h03) begin
      errors++;
      $display("FAIL read_hold: readdata got %0h expected 03", bus.readdata);
    end
    bus_read("read_ch3", 4'd3, 8'h07);
  endtask

  initial begin
    reset          = 1'b1;
    faster         = '0;
    slower         = '0;
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    bus.read       = 1'b0;
    bus.address    = '0;
    bus.writedata  = '0;
    #2;
    test_reset();
    test_hold_repeat();
    test_saturation();
    test_write();
    test_both_buttons();
    test_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
